wptr_ctrl_burst: RTL and testbench



---
 rtl/fifo_ptr_pkg.sv | 17 +
 rtl/wptr_ctrl_burst_gray2bin_conv.sv | 11 +
 rtl/wptr_ctrl_burst.sv | 60 ++++++
 tb/tb_wptr_ctrl_burst.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared pointer constants and binary/Gray conversion helpers
package fifo_ptr_pkg;
  localparam int PTR_MAX_W = 16;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  function automatic logic [PTR_MAX_W-1:0] width_mask(input int w);
    return (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
  endfunction
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b, input int w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g, input int w);
    logic [PTR_MAX_W-1:0] r;
    r = g & width_mask(w);
    for (int i = PTR_MAX_W-2; i >= 0; i--) r[i] = r[i] ^ r[i+1];
    return r;
  endfunction
endpackage

// File: rtl/wptr_ctrl_burst_gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary XOR prefix chain
module gray2bin_conv #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/wptr_ctrl_burst.sv
// wptr_ctrl_burst: multi-word async FIFO write pointer with fill/almost-full flags; sticky overflow and ovf_clr under WPTR_OVERFLOW_EN
module wptr_ctrl_burst
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_INC    = 4,
  parameter int INC_W      = $clog2(MAX_INC + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INC_W-1:0]      inc_cnt,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic [ADDR_WIDTH:0]   af_thresh,
`ifdef WPTR_OVERFLOW_EN
  input  logic                  ovf_clr,
`endif
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [INC_W-1:0]      acc_cnt,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wfill,
  output logic                  overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [PW-1:0] wbin, rbin, used, wbin_next, fill_next;
  logic [PW:0] free, req;
  gray2bin_conv #(.W(PW)) u_g2b (.gray(wq2_rptr), .bin(rbin));
  assign used = wbin - rbin;
  // a stale read pointer can never make used exceed DEPTH, but clamp anyway so free cannot go negative
  assign free = ({1'b0, used} > (PW+1)'(DEPTH)) ? '0 : (PW+1)'(DEPTH) - {1'b0, used};
  assign req = ((PW+1)'(inc_cnt) > (PW+1)'(MAX_INC)) ? (PW+1)'(MAX_INC) : (PW+1)'(inc_cnt);
  assign acc_cnt = INC_W'((req < free) ? req : free);
  assign wbin_next = wbin + PW'(acc_cnt);
  assign fill_next = wbin_next - rbin;
  assign waddr = wbin[ADDR_WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin <= '0;
      wptr <= '0;
      wfill <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wptr <= PW'(bin2gray(PTR_MAX_W'(wbin_next), PW));
      wfill <= fill_next;
      full <= (fill_next == PW'(DEPTH));
      almost_full <= (fill_next >= af_thresh);
    end
  end
`ifdef WPTR_OVERFLOW_EN
  // a fresh overflow in the same cycle as ovf_clr keeps the flag set
  always_ff @(posedge clk)
    overflow <= rst ? 1'b0 : (req > free) | (overflow & ~ovf_clr);
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_wptr_ctrl_burst.sv
// tb_wptr_ctrl_burst: directed self-checking bench for wptr_ctrl_burst (both WPTR_OVERFLOW_EN builds)
module tb_wptr_ctrl_burst;
`ifdef WPTR_OVERFLOW_EN
  localparam logic OVF = 1'b1;
  logic ovf_clr = 1'b0;
`else
  localparam logic OVF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] inc_cnt = '0;
  logic [6:0] wq2_rptr = '0;
  logic [6:0] af_thresh = 7'd60;
  logic [6:0] wptr, wfill, prev;
  logic [5:0] waddr;
  logic [2:0] acc_cnt;
  logic full, almost_full, overflow;
  int n_cmp = 0;
  int n_err = 0;
  wptr_ctrl_burst dut (
    .clk(clk), .rst(rst), .inc_cnt(inc_cnt), .wq2_rptr(wq2_rptr), .af_thresh(af_thresh),
`ifdef WPTR_OVERFLOW_EN
    .ovf_clr(ovf_clr),
`endif
    .wptr(wptr), .waddr(waddr), .acc_cnt(acc_cnt), .full(full), .almost_full(almost_full),
    .wfill(wfill), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] g(input int v);
    logic [6:0] b;
    b = 7'(v);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    inc_cnt = '0;
    wq2_rptr = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #1;
    for (int i = 0; i < 3; i++) begin
      inc_cnt = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    inc_cnt = '0;
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wfill", wfill, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    inc_cnt = 3'd1;
    #1 chk("first_acc", acc_cnt, 1);
    tick();
    chk("first_wptr", wptr, 7'b0000001);
    chk("first_wfill", wfill, 1);
    chk("first_waddr", waddr, 1);
    do_reset();
    inc_cnt = 3'd7;
    #1 chk("sat_acc", acc_cnt, 4);
    tick();
    chk("sat_wfill", wfill, 4);
    inc_cnt = 3'd4;
    for (int i = 0; i < 14; i++) tick();
    chk("fill60_wfill", wfill, 60);
    chk("fill60_full", full, 0);
    chk("fill60_af", almost_full, 1);
    tick();
    chk("fill_wfill", wfill, 64);
    chk("fill_full", full, 1);
    chk("fill_wptr", wptr, 7'b1100000);
    chk("fill_waddr", waddr, 0);
    chk("fill_ovf", overflow, 0);
    #1 chk("full_acc", acc_cnt, 0);
    tick();
    chk("full_wptr_hold", wptr, 7'b1100000);
    chk("full_wfill_hold", wfill, 64);
    chk("full_ovf", overflow, OVF);
    do_reset();
    chk("reset_clears_ovf", overflow, 0);
    inc_cnt = 3'd4;
    for (int i = 0; i < 15; i++) tick();
    inc_cnt = 3'd2;
    tick();
    chk("part_wfill62", wfill, 62);
    chk("part_ovf0", overflow, 0);
    inc_cnt = 3'd4;
    #1 chk("part_acc", acc_cnt, 2);
    tick();
    chk("part_full", full, 1);
    chk("part_wfill", wfill, 64);
    chk("part_ovf", overflow, OVF);
    inc_cnt = '0;
    tick();
    chk("ovf_sticky", overflow, OVF);
`ifdef WPTR_OVERFLOW_EN
    ovf_clr = 1'b1;
    inc_cnt = 3'd4;
    tick();
    chk("ovf_new_wins", overflow, 1);
    inc_cnt = '0;
    tick();
    chk("ovf_cleared", overflow, 0);
    ovf_clr = 1'b0;
`endif
    do_reset();
    inc_cnt = 3'd1;
    for (int i = 1; i <= 61; i++) begin
      tick();
      chk($sformatf("af_step%0d", i), almost_full, (i >= 60));
    end
    wq2_rptr = g(8);
    inc_cnt = '0;
    #1 chk("af_still_set", almost_full, 1);
    tick();
    chk("af_drain_wfill", wfill, 53);
    chk("af_drain", almost_full, 0);
    af_thresh = 7'd0;
    tick();
    chk("af_thresh0", almost_full, 1);
    af_thresh = 7'd65;
    tick();
    chk("af_thresh_big", almost_full, 0);
    af_thresh = 7'd60;
    do_reset();
    prev = wptr;
    for (int k = 0; k < 300; k++) begin
      wq2_rptr = g(k % 128);
      inc_cnt = 3'd1;
      tick();
      chk($sformatf("wrap_wptr%0d", k), wptr, g((k + 1) % 128));
      chk($sformatf("wrap_ham%0d", k), $countones(wptr ^ prev), 1);
      chk($sformatf("wrap_full%0d", k), full, 0);
      chk($sformatf("wrap_wfill%0d", k), wfill, 1);
      prev = wptr;
    end
    do_reset();
    inc_cnt = 3'd4;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_wfill40", wfill, 40);
    inc_cnt = 3'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inc_cnt = '0;
    chk("mid_wfill", wfill, 0);
    chk("mid_wptr", wptr, 0);
    chk("mid_waddr", waddr, 0);
    chk("mid_ovf", overflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
